// File: rtl/serial_as_pkg.sv
// Shared definitions for the bit-serial signed add/subtract unit.
// Holds the FSM state encoding, the default operand width and control codes.
// Imported by the top level and by the bench.
package serial_as_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;

    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

endpackage

// File: rtl/serial_as_full_adder.sv
// Single-bit full adder cell used by the serial datapath.
// Purely combinational, zero latency.
// No handshake; the caller sequences it one bit per clock.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Classic sum/majority equations.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_as.sv
// Bit-serial signed add/subtract, LSB first, one full-adder cell.
// Latency: result valid WIDTH cycles after the accept edge.
// Backpressure: holds DONE until out_ready; accepts only in IDLE.
module serial_as
    import serial_as_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt == LAST);

    full_adder u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept -> shift WIDTH bits -> wait for consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs come straight from the registered state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch operands on accept, then shift one bit per cycle.
    // Subtraction is x + ~y + 1, so the inverted operand and the initial
    // carry are set up once at accept time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa   <= x;
                        opb   <= control ? y : ~y;
                        carry <= ~control;
                        cnt   <= '0;
                        s     <= '0;
                    end
                end
                SHIFT: begin
                    s     <= {fa_sum, s[WIDTH-1:1]};
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    // On the MSB, carry holds the carry into the MSB.
                    if (last_bit) begin
                        cout <= fa_cout;
                        ovf  <= carry ^ fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_as.sv
// Self-checking bench for serial_as with a result scoreboard.
module tb_serial_as;
    import serial_as_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         control = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    res_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    serial_as #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: whole-word arithmetic, carry into MSB from the low bits.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b_in, input logic c);
        res_t         r;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   full;
        logic [W-1:0] low;
        b    = c ? b_in : ~b_in;
        cin  = ~c;
        full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(cin);
        r.s    = full[W-1:0];
        r.cout = full[W];
        r.ovf  = low[W-1] ^ full[W];
        return r;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x        = a;
        y        = b;
        control  = c;
        exp_q.push_back(model(a, b, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = W'($urandom);
        y        = W'($urandom);
        control  = 1'($urandom);
    endtask

    task automatic wait_done(input bit scramble);
        int cycles = 0;
        while (!out_valid && cycles < 40) begin
            if (scramble) begin
                x       = W'($urandom);
                y       = W'($urandom);
                control = 1'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
        end
        check_eq("latency", 32'(cycles), 32'(W));
    endtask

    task automatic collect();
        res_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("out_valid", 32'(out_valid), 32'd1);
        check_eq("s", 32'(s), 32'(e.s));
        check_eq("cout", 32'(cout), 32'(e.cout));
        check_eq("ovf", 32'(ovf), 32'(e.ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("out_valid_drop", 32'(out_valid), 32'd0);
        check_eq("in_ready_back", 32'(in_ready), 32'd1);
        check_eq("s_hold", 32'(s), 32'(e.s));
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        issue(a, b, c);
        wait_done(1'b0);
        collect();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        res_t e;
        // Reset state.
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_s", 32'(s), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed operand patterns (values are 4-bit two's complement).
        run_op(4'd5, 4'd3, ADD);   // 1000 cout0 ovf1
        run_op(4'd7, 4'd2, ADD);   // 1001 cout0 ovf1
        run_op(4'd6, 4'hB, SUB);   // 6 - (-5): 1011 cout0 ovf1
        run_op(4'd5, 4'd3, SUB);   // 0010 cout1 ovf0
        run_op(4'd3, 4'd5, SUB);   // 1110 cout0 ovf0

        // Backpressure: hold the result while in_valid pulses are ignored.
        issue(4'd4, 4'd4, ADD);
        wait_done(1'b0);
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x        = W'($urandom);
            @(posedge clk); #1;
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_s", 32'(s), 32'(e.s));
            check_eq("bp_cout", 32'(cout), 32'(e.cout));
        end
        in_valid = 1'b0;
        collect();

        // Operands change every SHIFT cycle; latched values must be used.
        issue(4'h8, 4'd1, SUB);     // -8 - 1: 0111 cout1 ovf1
        wait_done(1'b1);
        collect();

        // Reset mid-SHIFT after two bits.
        issue(4'd3, 4'd3, ADD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_s", 32'(s), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(4'd1, 4'd1, ADD);   // 0010

        // Random operands, out_ready sometimes raised before out_valid.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            issue(a, b, c);
            out_ready = 1'($urandom);
            wait_done(1'b0);
            collect();
        end

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
